// File: rtl/uart_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_boot_loader                                               |
// | Purpose : 8N1 UART receiver feeding a boot-protocol engine. Parses a     |
// |           framed program image (MAGIC, LEN lo/hi, LEN little-endian      |
// |           words, XOR checksum), writes each word into instruction        |
// |           memory and holds the core in reset until a checksum-valid      |
// |           image has landed.                                              |
// | Ports   : i_clk        clock (single domain)                             |
// |           i_rst        asynchronous active-high reset                    |
// |           i_clk_en     clock enable; all state except the rx            |
// |                        synchroniser advances only when high              |
// |           i_rx         asynchronous UART line, idle high                 |
// |           o_mem_we     instruction-memory write strobe (qualify with     |
// |                        i_clk_en at the memory)                           |
// |           o_mem_addr   word address of the write                         |
// |           o_mem_wdata  32-bit write data                                 |
// |           o_core_rst   core reset, high until boot completes             |
// |           o_booted     sticky boot-complete flag                         |
// |           o_err        one-enabled-cycle protocol/framing error pulse    |
// | Params  : CLKS_PER_BIT (>=4, even), ADDR_W, MAGIC                        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module uart_boot_loader #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         ADDR_W       = 12,
  parameter logic [7:0] MAGIC        = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_rst,
  output logic              o_booted,
  output logic              o_err
);

  localparam int                  c_TICK_W  = $clog2(CLKS_PER_BIT);
  localparam logic [c_TICK_W-1:0] c_HALF_M1 = c_TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_TICK_W-1:0] c_FULL_M1 = c_TICK_W'(CLKS_PER_BIT - 1);
  // Largest image the memory can hold, in words; 33 bits so any ADDR_W up
  // to 32 compares cleanly against a 16-bit length.
  localparam logic [32:0]         c_MAX_LEN = 33'(1) << ADDR_W;

  // --------------------------------------------------------------------------
  // RX synchroniser: free-running on i_clk so metastability settles even
  // while the enable is low. Resets to the idle (high) line level.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Byte receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t           r_rx_state;
  logic [c_TICK_W-1:0] r_tick;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_rx_prev;

  logic                w_stop_sample;
  logic                w_byte_valid;
  logic                w_frame_err;
  logic [7:0]          w_byte;

  // The stop-bit sample is consumed by the protocol engine in the same edge,
  // so its registered outputs appear in the enabled cycle that follows.
  assign w_stop_sample = i_clk_en && (r_rx_state == RX_STOP) && (r_tick == c_FULL_M1);
  assign w_byte_valid  = w_stop_sample &&  r_rx_sync;
  assign w_frame_err   = w_stop_sample && !r_rx_sync;
  assign w_byte        = r_shift;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_state <= RX_IDLE;
      r_tick     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_prev  <= 1'b1;
    end else if (i_clk_en) begin
      // Previous line level tracked every enabled tick, so a start edge right
      // after the stop-bit sample is seen without an extra idle cycle.
      r_rx_prev <= r_rx_sync;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_tick     <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Mid-start-bit check: a line back high here was a glitch.
          if (r_tick == c_HALF_M1) begin
            r_tick    <= '0;
            r_bit_idx <= '0;
            if (r_rx_sync) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_tick == c_FULL_M1) begin
            r_tick  <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};   // LSB arrives first
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_tick == c_FULL_M1) begin
            r_tick     <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Boot protocol engine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_MAGIC = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            r_state;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_words_left;
  logic [ADDR_W-1:0] r_addr;
  logic [23:0]       r_word;      // first three bytes of the word in flight
  logic [1:0]        r_bcnt;
  logic [7:0]        r_csum;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_core_rst;
  logic              r_booted;
  logic              r_err;

  logic [15:0]       w_len;
  logic              w_len_bad;

  assign w_len     = {w_byte, r_len_lo};
  assign w_len_bad = (w_len == 16'd0) || ({17'd0, w_len} > c_MAX_LEN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_MAGIC;
      r_len_lo     <= '0;
      r_words_left <= '0;
      r_addr       <= '0;
      r_word       <= '0;
      r_bcnt       <= '0;
      r_csum       <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rst   <= 1'b1;
      r_booted     <= 1'b0;
      r_err        <= 1'b0;
    end else if (i_clk_en) begin
      // Strobes last exactly one enabled cycle.
      r_mem_we <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_MAGIC: begin
          // Noise and framing errors before a frame starts are ignored.
          if (w_byte_valid && (w_byte == MAGIC)) begin
            r_state <= S_LEN0;
          end
        end
        S_LEN0: begin
          if (w_frame_err) begin
            r_state <= S_ERR;
          end else if (w_byte_valid) begin
            r_len_lo <= w_byte;
            r_state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_frame_err) begin
            r_state <= S_ERR;
          end else if (w_byte_valid) begin
            if (w_len_bad) begin
              r_state <= S_ERR;
            end else begin
              r_words_left <= w_len;
              r_addr       <= '0;
              r_csum       <= '0;
              r_bcnt       <= '0;
              r_state      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_frame_err) begin
            r_state <= S_ERR;
          end else if (w_byte_valid) begin
            r_csum <= r_csum ^ w_byte;
            r_word <= {w_byte, r_word[23:8]};
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_addr;
              r_mem_wdata  <= {w_byte, r_word};
              r_addr       <= r_addr + ADDR_W'(1);
              r_words_left <= r_words_left - 16'd1;
              if (r_words_left == 16'd1) begin
                r_state <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (w_frame_err) begin
            r_state <= S_ERR;
          end else if (w_byte_valid) begin
            if (w_byte == r_csum) begin
              r_booted   <= 1'b1;
              r_core_rst <= 1'b0;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_DONE: begin
          // Terminal until reset; further traffic is deliberately ignored.
          r_state <= S_DONE;
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_state <= S_MAGIC;
        end
        default: r_state <= S_MAGIC;
      endcase
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_core_rst  = r_core_rst;
  assign o_booted    = r_booted;
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_uart_boot_loader                                            |
// | Purpose : Self-checking bench for uart_boot_loader. A byte-stream        |
// |           reference model queues expected memory writes and error        |
// |           pulses as each byte is sent; a monitor pops and compares them  |
// |           whenever the DUT strobes o_mem_we or o_err.                    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_uart_boot_loader;

  localparam int         c_CPB   = 16;
  localparam int         c_AW    = 12;
  localparam logic [7:0] c_MAGIC = 8'hA5;

  logic              clk;
  logic              rst;
  logic              clk_en;
  logic              rx;
  logic              mem_we;
  logic [c_AW-1:0]   mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              booted;
  logic              err;

  uart_boot_loader #(
    .CLKS_PER_BIT(c_CPB),
    .ADDR_W      (c_AW),
    .MAGIC       (c_MAGIC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clk_en   (clk_en),
    .i_rx       (rx),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_core_rst (core_rst),
    .o_booted   (booted),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int en_div   = 1;   // 1: enable always high, 3: enable high one cycle in three
  int bit_clks = c_CPB;

  // Enable changes just after the rising edge, so it is stable at the
  // falling edge where the monitor samples.
  initial begin
    int ph;
    ph     = 0;
    clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph     = (ph + 1) % 3;
      clk_en = (en_div == 1) ? 1'b1 : (ph == 0);
    end
  end

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    bit          is_err;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic sb_pop(input bit is_err, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: err=%0d addr=%h data=%h while nothing expected", is_err, addr, data);
      return;
    end
    e = exp_q.pop_front();
    if ((e.is_err != is_err) || (!is_err && ((e.addr !== addr) || (e.data !== data)))) begin
      n_fail++;
      $display("FAIL sb_event: got err=%0d addr=%h data=%h expected err=%0d addr=%h data=%h",
               is_err, addr, data, e.is_err, e.addr, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (clk_en && !rst) begin
      if (mem_we) sb_pop(1'b0, 32'(mem_addr), mem_wdata);
      if (err)    sb_pop(1'b1, 32'd0, 32'd0);
    end
  end

  // ------------------------------------------------------------ reference model
  // Keeps the bytes of the current frame in a queue and decides outcomes from
  // their positions: header length, word boundaries, final checksum byte.
  bit           m_booted  = 1'b0;
  bit           m_inframe = 1'b0;
  byte unsigned m_frame[$];

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
    m_inframe = 1'b0;
  endtask

  task automatic model_byte(input byte unsigned b, input bit ferr);
    int n, len;
    byte unsigned cs;
    ev_t e;
    if (m_booted) return;
    if (!m_inframe) begin
      if (!ferr && (b == c_MAGIC)) begin
        m_inframe = 1'b1;
        m_frame.delete();
      end
      return;
    end
    if (ferr) begin
      push_err();
      return;
    end
    m_frame.push_back(b);
    n = m_frame.size();
    if (n < 2) return;
    len = int'(m_frame[0]) + 256 * int'(m_frame[1]);
    if (n == 2) begin
      if ((len == 0) || (len > (1 << c_AW))) push_err();
      return;
    end
    if (n <= 2 + 4 * len) begin
      if (((n - 2) % 4) == 0) begin
        e.is_err = 1'b0;
        e.addr   = 32'((n - 2) / 4 - 1);
        e.data   = {m_frame[n-1], m_frame[n-2], m_frame[n-3], m_frame[n-4]};
        exp_q.push_back(e);
      end
      return;
    end
    cs = 8'h00;
    for (int i = 2; i < n - 1; i++) cs = cs ^ m_frame[i];
    if (b == cs) begin
      m_booted  = 1'b1;
      m_inframe = 1'b0;
    end else begin
      push_err();
    end
  endtask

  // ------------------------------------------------------------------ drivers
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input byte unsigned b, input bit stop = 1'b1);
    byte unsigned v;
    v = b;
    model_byte(b, !stop);
    rx = 1'b0;
    wait_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      wait_clks(bit_clks);
    end
    rx = stop;
    wait_clks(bit_clks);
    if (!stop) begin
      rx = 1'b1;
      wait_clks(bit_clks);
    end
    wait_clks(2);
  endtask

  task automatic send_seq(input byte unsigned s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic check_idle(input string name);
    wait_clks(2 * bit_clks);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_booted"},  32'(booted),       32'(m_booted));
    check({name, "_corerst"}, 32'(core_rst),     32'(!m_booted));
    exp_q.delete();
  endtask

  task automatic reset_checks(input string name);
    @(negedge clk);
    check({name, "_we"},      32'(mem_we),    32'd0);
    check({name, "_err"},     32'(err),       32'd0);
    check({name, "_booted"},  32'(booted),    32'd0);
    check({name, "_corerst"}, 32'(core_rst),  32'd1);
    check({name, "_addr"},    32'(mem_addr),  32'd0);
    check({name, "_wdata"},   mem_wdata,      32'd0);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(4);
    reset_checks(name);
    wait_clks(1);
    rst = 1'b0;
    m_booted  = 1'b0;
    m_inframe = 1'b0;
    m_frame.delete();
    wait_clks(4);
  endtask

  // Reset asserted in the middle of a byte that belongs to a partly sent frame.
  task automatic reset_mid_byte();
    send_seq('{8'hA5, 8'h02, 8'h00, 8'h78});
    rx = 1'b0;
    wait_clks(bit_clks);
    rx = 1'b1;
    wait_clks(bit_clks);
    rx = 1'b0;
    wait_clks(bit_clks / 2);
    do_reset("t1_midbyte");
  endtask

  task automatic glitch();
    rx = 1'b0;
    wait_clks(7 * en_div);
    rx = 1'b1;
    wait_clks(2 * bit_clks);
  endtask

  task automatic random_frame(input bit good_csum);
    int nw, nnoise;
    byte unsigned cs, b;
    nnoise = int'($urandom_range(0, 2));
    for (int i = 0; i < nnoise; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == c_MAGIC) b = 8'h00;
      send_byte(b, 1'($urandom_range(0, 1)));
    end
    nw = int'($urandom_range(1, 2));
    send_byte(c_MAGIC);
    send_byte(8'(nw));
    send_byte(8'h00);
    cs = 8'h00;
    for (int i = 0; i < 4 * nw; i++) begin
      b  = 8'($urandom);
      cs = cs ^ b;
      send_byte(b);
    end
    if (!good_csum) cs = cs ^ 8'($urandom_range(1, 255));
    send_byte(cs);
  endtask

  // ------------------------------------------------------------------ sequence
  byte unsigned t2[$]  = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
  byte unsigned t3[$]  = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
  byte unsigned t6[$]  = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
  byte unsigned pre[$] = '{8'h00, 8'hFF, 8'h5A};

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    do_reset("reset");

    // ---- enable tied high
    reset_mid_byte();
    send_seq(t2);
    check_idle("t1_t2_load");

    send_seq(t6);
    check_idle("t6_postboot");

    do_reset("r_t3");
    send_seq(t3);
    check_idle("t3_badcsum");
    send_seq(t2);
    check_idle("t3_resend");

    do_reset("r_t4");
    send_seq(pre);
    send_seq(t2);
    check_idle("t4_preamble");

    do_reset("r_t5");
    send_seq('{8'hA5, 8'h02, 8'h00});
    send_byte(8'h78, 1'b0);
    check_idle("t5_stop0");
    send_seq('{8'hA5, 8'h00, 8'h00});
    check_idle("t5_len0");
    send_seq('{8'hA5, 8'h01, 8'h10});
    check_idle("t5_lenbig");
    glitch();
    check_idle("t5_glitch");

    random_frame(1'b0);
    check_idle("rand_bad");
    random_frame(1'b1);
    check_idle("rand_good");

    // ---- enable high one cycle in three
    rst = 1'b1;
    en_div   = 3;
    bit_clks = c_CPB * 3;
    do_reset("en3_reset");
    send_seq('{8'hA5, 8'h02, 8'h00});
    send_byte(8'h56, 1'b0);
    check_idle("en3_stop0");
    glitch();
    check_idle("en3_glitch");
    send_seq(t3);
    check_idle("en3_badcsum");
    send_seq(t2);
    check_idle("en3_load");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #950_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
